// File: rtl/boot_sequencer.sv
// Autonomous boot controller: copies a binary image over a single-outstanding OBI-style
// master, releases the selected harts at the entry point, then polls the EOC register.
module boot_sequencer #(
  parameter int NumHarts     = 1,
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16,
  parameter int PollCycles   = 256,
  parameter int TimeoutPolls = 4096
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [AddrWidth-1:0]                src_base_i,
  input  logic [AddrWidth-1:0]                dst_base_i,
  input  logic [LenWidth-1:0]                 len_i,
  input  logic [AddrWidth-1:0]                entry_point_i,
  input  logic [NumHarts-1:0]                 hart_mask_i,
  input  logic [AddrWidth-1:0]                eoc_addr_i,
  output logic                                req_o,
  input  logic                                gnt_i,
  output logic [AddrWidth-1:0]                addr_o,
  output logic                                we_o,
  output logic [DataWidth-1:0]                wdata_o,
  input  logic                                rvalid_i,
  input  logic [DataWidth-1:0]                rdata_i,
  output logic [NumHarts-1:0][AddrWidth-1:0]  boot_addr_o,
  output logic [NumHarts-1:0]                 fetch_en_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                error_o,
  output logic [30:0]                         exit_status_o
);

  localparam int Stride = DataWidth / 8;
  localparam int WaitW  = (PollCycles > 1) ? $clog2(PollCycles) : 1;
  localparam int PollW  = $clog2(TimeoutPolls + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_BOOT,
    ST_POLL_IDLE,
    ST_POLL_REQ,
    ST_POLL_WAIT,
    ST_DONE
  } state_t;

  state_t                              r_state, w_state_nxt;

  logic                                r_req, w_req_nxt;
  logic                                r_we, w_we_nxt;
  logic [AddrWidth-1:0]                r_addr, w_addr_nxt;
  logic [DataWidth-1:0]                r_wdata, w_wdata_nxt;
  logic [NumHarts-1:0][AddrWidth-1:0]  r_boot_addr, w_boot_nxt;
  logic [NumHarts-1:0]                 r_fetch_en, w_fetch_nxt;
  logic                                r_busy, w_busy_nxt;
  logic                                r_done, w_done_nxt;
  logic                                r_error, w_error_nxt;
  logic [30:0]                         r_exit, w_exit_nxt;

  logic [LenWidth-1:0]                 r_word_cnt, w_word_cnt_nxt;
  logic [WaitW-1:0]                    r_wait_cnt, w_wait_cnt_nxt;
  logic [PollW-1:0]                    r_poll_cnt, w_poll_cnt_nxt;

  logic [AddrWidth-1:0]                r_src_ptr, w_src_nxt;
  logic [AddrWidth-1:0]                r_dst_ptr, w_dst_nxt;
  logic [AddrWidth-1:0]                r_eoc_addr, w_eoc_nxt;
  logic [AddrWidth-1:0]                r_entry, w_entry_nxt;
  logic [LenWidth-1:0]                 r_len, w_len_nxt;
  logic [NumHarts-1:0]                 r_mask, w_mask_nxt;
  logic [DataWidth-1:0]                r_buf, w_buf_nxt;

  logic [LenWidth-1:0]                 w_word_inc;
  logic [PollW-1:0]                    w_poll_inc;

  assign w_word_inc = r_word_cnt + LenWidth'(1);
  assign w_poll_inc = r_poll_cnt + PollW'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src_ptr;
    w_dst_nxt      = r_dst_ptr;
    w_eoc_nxt      = r_eoc_addr;
    w_entry_nxt    = r_entry;
    w_len_nxt      = r_len;
    w_mask_nxt     = r_mask;
    w_buf_nxt      = r_buf;
    w_word_cnt_nxt = r_word_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_poll_cnt_nxt = r_poll_cnt;
    w_boot_nxt     = r_boot_addr;
    w_fetch_nxt    = r_fetch_en;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_exit_nxt     = r_exit;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_src_nxt      = src_base_i;
          w_dst_nxt      = dst_base_i;
          w_eoc_nxt      = eoc_addr_i;
          w_entry_nxt    = entry_point_i;
          w_len_nxt      = len_i;
          w_mask_nxt     = hart_mask_i;
          w_word_cnt_nxt = '0;
          w_wait_cnt_nxt = '0;
          w_poll_cnt_nxt = '0;
          w_fetch_nxt    = '0;
          w_done_nxt     = 1'b0;
          w_error_nxt    = 1'b0;
          w_exit_nxt     = '0;
          w_state_nxt    = (len_i == '0) ? ST_BOOT : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (gnt_i) w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rvalid_i) begin
          w_buf_nxt   = rdata_i;
          w_state_nxt = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (gnt_i) w_state_nxt = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (rvalid_i) begin
          w_src_nxt      = r_src_ptr + AddrWidth'(Stride);
          w_dst_nxt      = r_dst_ptr + AddrWidth'(Stride);
          w_word_cnt_nxt = w_word_inc;
          w_state_nxt    = (w_word_inc == r_len) ? ST_BOOT : ST_RD_REQ;
        end
      end
      ST_BOOT: begin
        // Harts outside the mask keep whatever boot address they had before.
        for (int i = 0; i < NumHarts; i++) begin
          if (r_mask[i]) w_boot_nxt[i] = r_entry;
        end
        w_fetch_nxt    = r_mask;
        w_wait_cnt_nxt = '0;
        w_state_nxt    = ST_POLL_IDLE;
      end
      ST_POLL_IDLE: begin
        if (r_wait_cnt == WaitW'(PollCycles - 1)) begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = ST_POLL_REQ;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WaitW'(1);
        end
      end
      ST_POLL_REQ: begin
        if (gnt_i) w_state_nxt = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (rvalid_i) begin
          if (rdata_i[31]) begin
            w_exit_nxt  = rdata_i[30:0];
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end else if (w_poll_inc == PollW'(TimeoutPolls)) begin
            w_poll_cnt_nxt = w_poll_inc;
            w_error_nxt    = 1'b1;
            w_done_nxt     = 1'b1;
            w_state_nxt    = ST_DONE;
          end else begin
            w_poll_cnt_nxt = w_poll_inc;
            w_state_nxt    = ST_POLL_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Bus outputs are registered from the state being entered, so they hold until gnt.
    w_req_nxt   = 1'b0;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    case (w_state_nxt)
      ST_RD_REQ: begin
        w_req_nxt  = 1'b1;
        w_we_nxt   = 1'b0;
        w_addr_nxt = w_src_nxt;
      end
      ST_WR_REQ: begin
        w_req_nxt   = 1'b1;
        w_we_nxt    = 1'b1;
        w_addr_nxt  = w_dst_nxt;
        w_wdata_nxt = w_buf_nxt;
      end
      ST_POLL_REQ: begin
        w_req_nxt  = 1'b1;
        w_we_nxt   = 1'b0;
        w_addr_nxt = w_eoc_nxt;
      end
      default: ;
    endcase

    w_busy_nxt = !(w_state_nxt inside {ST_IDLE, ST_DONE});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_boot_addr <= '0;
      r_fetch_en  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_exit      <= '0;
      r_word_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_poll_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_boot_addr <= w_boot_nxt;
      r_fetch_en  <= w_fetch_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_exit      <= w_exit_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_poll_cnt  <= w_poll_cnt_nxt;
    end
  end

  // Job parameters and the copy buffer are always rewritten before use.
  always_ff @(posedge clk_i) begin
    r_src_ptr  <= w_src_nxt;
    r_dst_ptr  <= w_dst_nxt;
    r_eoc_addr <= w_eoc_nxt;
    r_entry    <= w_entry_nxt;
    r_len      <= w_len_nxt;
    r_mask     <= w_mask_nxt;
    r_buf      <= w_buf_nxt;
  end

  assign req_o         = r_req;
  assign we_o          = r_we;
  assign addr_o        = r_addr;
  assign wdata_o       = r_wdata;
  assign boot_addr_o   = r_boot_addr;
  assign fetch_en_o    = r_fetch_en;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign error_o       = r_error;
  assign exit_status_o = r_exit;

endmodule
